// File: rtl/ws2812_frame_sequencer_if.sv
// Pixel stream between the framebuffer reader (master) and the WS2812 frame
// sequencer (slave); a transfer happens on a cycle with valid and ready both high.
interface ws2812_frame_sequencer_if #(
  parameter int PIXEL_BITS = 24
);
  logic [PIXEL_BITS-1:0] pixel_data;
  logic                  pixel_last;
  logic                  pixel_valid;
  logic                  pixel_ready;

  modport master (
    output pixel_data,
    output pixel_last,
    output pixel_valid,
    input  pixel_ready
  );

  modport slave (
    input  pixel_data,
    input  pixel_last,
    input  pixel_valid,
    output pixel_ready
  );
endinterface

// File: rtl/ws2812_frame_sequencer.sv
// Serialises pixels MSB-first onto the WS2812 encoder command/databit inputs,
// gapless across a frame, then holds the line idle for the latch interval.
//
// state    | meaning
// ST_IDLE  | line idle, ready for the first pixel of a frame
// ST_SHIFT | transmitting the current pixel, one bit per BIT_CYCLES cycles
// ST_LATCH | line idle for LATCH_CYCLES cycles, pixel stream ignored
module ws2812_frame_sequencer #(
  parameter int BIT_CYCLES   = 3,
  parameter int PIXEL_BITS   = 24,
  parameter int LATCH_CYCLES = 1000
) (
  input  logic                    clk_3p33mhz,
  input  logic                    rst,
  ws2812_frame_sequencer_if.slave pix_if,
  output logic [1:0]              enc_command_o,
  output logic                    enc_databit_o,
  output logic                    busy_o,
  output logic                    frame_done_o,
  output logic                    underrun_o,
  output logic [15:0]             frame_pixels_o
);

  localparam int SW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BW = (PIXEL_BITS > 1) ? $clog2(PIXEL_BITS) : 1;
  localparam int LW = $clog2(LATCH_CYCLES + 1);

  localparam logic [SW-1:0] SLOT_LAST  = SW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(PIXEL_BITS - 1);
  localparam logic [LW-1:0] LATCH_LOAD = LW'(LATCH_CYCLES - 1);
  localparam logic [1:0]    CMD_IDLE   = 2'b00;
  localparam logic [1:0]    CMD_TX     = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [PIXEL_BITS-1:0] sr_q, sr_d;
  logic                  last_q, last_d;
  logic [SW-1:0]         slot_q, slot_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [LW-1:0]         latch_q, latch_d;
  logic [15:0]           pix_q, pix_d;
  logic [1:0]            cmd_q, cmd_d;
  logic                  databit_q, databit_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;
  logic                  underrun_q, underrun_d;
  logic [15:0]           frame_pixels_q, frame_pixels_d;

  logic                  slot_end;
  logic                  pixel_end;
  logic                  ready;
  logic                  xfer;
  logic                  load;
  logic                  eof;
  logic [PIXEL_BITS-1:0] sr_shifted;

  assign sr_shifted = sr_q << 1;
  assign slot_end   = (slot_q == SLOT_LAST);
  assign pixel_end  = slot_end && (bit_q == BIT_LAST);

  // The next pixel is only taken in the final cycle of the current one so the
  // bit stream stays gapless without a holding register.
  assign ready = (state_q == ST_IDLE) ||
                 ((state_q == ST_SHIFT) && pixel_end && !last_q);
  assign xfer  = pix_if.pixel_valid && ready;

  assign pix_if.pixel_ready = ready;

  always_comb begin
    state_d        = state_q;
    sr_d           = sr_q;
    last_d         = last_q;
    slot_d         = slot_q;
    bit_d          = bit_q;
    latch_d        = latch_q;
    pix_d          = pix_q;
    cmd_d          = cmd_q;
    databit_d      = databit_q;
    frame_pixels_d = frame_pixels_q;
    frame_done_d   = 1'b0;
    underrun_d     = 1'b0;
    load           = 1'b0;
    eof            = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        load = xfer;
      end
      ST_SHIFT: begin
        if (slot_end) begin
          slot_d = '0;
          if (!pixel_end) begin
            sr_d      = sr_shifted;
            databit_d = sr_shifted[PIXEL_BITS-1];
            bit_d     = bit_q + 1'b1;
          end else if (last_q) begin
            eof = 1'b1;
          end else if (xfer) begin
            load = 1'b1;
          end else begin
            underrun_d = 1'b1;
            eof        = 1'b1;
          end
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end
      ST_LATCH: begin
        if (latch_q == '0) begin
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
        end else begin
          latch_d = latch_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (load) begin
      sr_d      = pix_if.pixel_data;
      last_d    = pix_if.pixel_last;
      cmd_d     = CMD_TX;
      databit_d = pix_if.pixel_data[PIXEL_BITS-1];
      slot_d    = '0;
      bit_d     = '0;
      state_d   = ST_SHIFT;
      if (state_q == ST_IDLE) begin
        pix_d = 16'd1;
      end else if (pix_q != 16'hFFFF) begin
        pix_d = pix_q + 16'd1;
      end
    end

    if (eof) begin
      cmd_d          = CMD_IDLE;
      databit_d      = 1'b0;
      frame_pixels_d = pix_q;
      latch_d        = LATCH_LOAD;
      state_d        = ST_LATCH;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_3p33mhz or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      sr_q           <= '0;
      last_q         <= 1'b0;
      slot_q         <= '0;
      bit_q          <= '0;
      latch_q        <= '0;
      pix_q          <= '0;
      cmd_q          <= CMD_IDLE;
      databit_q      <= 1'b0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
      underrun_q     <= 1'b0;
      frame_pixels_q <= '0;
    end else begin
      state_q        <= state_d;
      sr_q           <= sr_d;
      last_q         <= last_d;
      slot_q         <= slot_d;
      bit_q          <= bit_d;
      latch_q        <= latch_d;
      pix_q          <= pix_d;
      cmd_q          <= cmd_d;
      databit_q      <= databit_d;
      busy_q         <= busy_d;
      frame_done_q   <= frame_done_d;
      underrun_q     <= underrun_d;
      frame_pixels_q <= frame_pixels_d;
    end
  end

  assign enc_command_o  = cmd_q;
  assign enc_databit_o  = databit_q;
  assign busy_o         = busy_q;
  assign frame_done_o   = frame_done_q;
  assign underrun_o     = underrun_q;
  assign frame_pixels_o = frame_pixels_q;

endmodule

// File: tb/tb_ws2812_frame_sequencer.sv
// Bench for ws2812_frame_sequencer: per-cycle traces of each frame are compared
// against a timeline built from the pixel list, bit cadence and latch length.
`timescale 1ns/1ps
module tb_ws2812_frame_sequencer;
  localparam int BC   = 3;
  localparam int PB   = 24;
  localparam int LC   = 5;
  localparam int FB   = PB * BC;
  localparam int MAXC = 1024;
  localparam int NSAT = 65537;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ws2812_frame_sequencer_if #(.PIXEL_BITS(PB)) a_if ();
  ws2812_frame_sequencer_if #(.PIXEL_BITS(1))  b_if ();

  logic [1:0]  a_cmd, b_cmd;
  logic        a_bit, b_bit, a_busy, b_busy, a_fd, b_fd, a_ur, b_ur;
  logic [15:0] a_fp, b_fp;

  ws2812_frame_sequencer #(.BIT_CYCLES(BC), .PIXEL_BITS(PB), .LATCH_CYCLES(LC)) dut_a (
    .clk_3p33mhz(clk), .rst(rst), .pix_if(a_if),
    .enc_command_o(a_cmd), .enc_databit_o(a_bit), .busy_o(a_busy),
    .frame_done_o(a_fd), .underrun_o(a_ur), .frame_pixels_o(a_fp)
  );

  ws2812_frame_sequencer #(.BIT_CYCLES(1), .PIXEL_BITS(1), .LATCH_CYCLES(1)) dut_b (
    .clk_3p33mhz(clk), .rst(rst), .pix_if(b_if),
    .enc_command_o(b_cmd), .enc_databit_o(b_bit), .busy_o(b_busy),
    .frame_done_o(b_fd), .underrun_o(b_ur), .frame_pixels_o(b_fp)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [23:0] pix [8];
  int          npix;

  logic [1:0]  tr_cmd  [MAXC];
  logic        tr_bit  [MAXC];
  logic        tr_rdy  [MAXC];
  logic        tr_busy [MAXC];
  logic        tr_fd   [MAXC];
  logic        tr_ur   [MAXC];
  logic        tr_acc  [MAXC];
  logic [15:0] tr_fp   [MAXC];

  // Presents pix[0..npix-1] back to back and records one trace entry per cycle
  // until frame_done (inclusive) or the cycle budget runs out.
  task automatic drive_frame(input bit mark_last, input bit keep_valid,
                             input logic [23:0] next_pix,
                             output int ncyc, output bit got_fd);
    int idx = 0;
    ncyc   = 0;
    got_fd = 1'b0;
    while (ncyc < MAXC && !got_fd) begin
      @(negedge clk);
      if (idx < npix) begin
        a_if.pixel_valid = 1'b1;
        a_if.pixel_data  = pix[idx];
        a_if.pixel_last  = mark_last && (idx == npix - 1);
      end else if (keep_valid) begin
        a_if.pixel_valid = 1'b1;
        a_if.pixel_data  = next_pix;
        a_if.pixel_last  = 1'b1;
      end else begin
        a_if.pixel_valid = 1'b0;
        a_if.pixel_data  = 24'($urandom);
        a_if.pixel_last  = 1'($urandom_range(0, 1));
      end
      tr_cmd[ncyc]  = a_cmd;
      tr_bit[ncyc]  = a_bit;
      tr_rdy[ncyc]  = a_if.pixel_ready;
      tr_busy[ncyc] = a_busy;
      tr_fd[ncyc]   = a_fd;
      tr_ur[ncyc]   = a_ur;
      tr_fp[ncyc]   = a_fp;
      tr_acc[ncyc]  = a_if.pixel_valid && a_if.pixel_ready;
      if (tr_acc[ncyc]) idx++;
      got_fd = (a_fd === 1'b1);
      ncyc++;
    end
    @(posedge clk);
    #1;
    a_if.pixel_valid = 1'b0;
  endtask

  // Reference timeline: TX onset one cycle after the first transfer, npix*FB TX
  // cycles, LC latch cycles, frame_done in the following cycle.
  task automatic check_frame(input string name, input bit mark_last, input bit keep_valid,
                             input int ncyc, input bit got_fd);
    int          t0 = 1;
    int          rel;
    int          bad [7];
    int          fc  [7];
    int          fa  [7];
    int          fw  [7];
    logic [1:0]  act  [7];
    logic [1:0]  want [7];
    string       pname [7];
    logic [23:0] p;
    pname = '{"enc_command", "enc_databit", "pixel_ready", "busy", "frame_done", "underrun", "transfer"};
    for (int k = 0; k < 7; k++) begin
      bad[k] = 0; fc[k] = 0; fa[k] = 0; fw[k] = 0;
    end

    n_checks++;
    if (got_fd !== 1'b1) begin
      n_fail++;
      $display("FAIL %s frame_done_seen: got none within %0d cycles, required one", name, MAXC);
    end
    n_checks++;
    if (ncyc !== t0 + npix * FB + LC + 1) begin
      n_fail++;
      $display("FAIL %s frame_length: got frame_done at cycle %0d, required %0d", name, ncyc - 1, t0 + npix * FB + LC);
    end

    for (int c = 0; c < ncyc; c++) begin
      rel = c - t0;
      want[0] = (rel >= 0 && rel < npix * FB) ? 2'b01 : 2'b00;
      if (want[0] == 2'b01) begin
        p = pix[rel / FB];
        want[1] = {1'b0, p[PB - 1 - (rel % FB) / BC]};
      end else begin
        want[1] = 2'b00;
      end
      if (rel < 0)                 want[2] = 2'b01;
      else if (rel < npix * FB)    want[2] = {1'b0, (rel % FB == FB - 1) && ((rel / FB < npix - 1) || !mark_last)};
      else if (rel < npix * FB + LC) want[2] = 2'b00;
      else                         want[2] = 2'b01;
      want[3] = {1'b0, rel >= 0 && rel < npix * FB + LC};
      want[4] = {1'b0, rel == npix * FB + LC};
      want[5] = {1'b0, !mark_last && rel == npix * FB};
      want[6] = {1'b0, (rel == -1) ||
                       (rel >= 0 && rel < npix * FB && rel % FB == FB - 1 && rel / FB < npix - 1) ||
                       (keep_valid && rel == npix * FB + LC)};
      act[0] = tr_cmd[c];
      act[1] = {1'b0, tr_bit[c]};
      act[2] = {1'b0, tr_rdy[c]};
      act[3] = {1'b0, tr_busy[c]};
      act[4] = {1'b0, tr_fd[c]};
      act[5] = {1'b0, tr_ur[c]};
      act[6] = {1'b0, tr_acc[c]};
      for (int k = 0; k < 7; k++) begin
        if (act[k] !== want[k]) begin
          if (bad[k] == 0) begin
            fc[k] = c; fa[k] = int'(act[k]); fw[k] = int'(want[k]);
          end
          bad[k]++;
        end
      end
    end

    for (int k = 0; k < 7; k++) begin
      n_checks++;
      if (bad[k] !== 0) begin
        n_fail++;
        $display("FAIL %s %s: %0d bad cycles, first at cycle %0d got %0d required %0d",
                 name, pname[k], bad[k], fc[k], fa[k], fw[k]);
      end
    end

    n_checks++;
    if (tr_fp[ncyc - 1] !== 16'(npix)) begin
      n_fail++;
      $display("FAIL %s frame_pixels: got %0d required %0d", name, tr_fp[ncyc - 1], npix);
    end
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (a_cmd !== 2'b00 || a_bit !== 1'b0 || a_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_line: got cmd=%0d bit=%0d busy=%0d required 0 0 0", a_cmd, a_bit, a_busy);
    end
    n_checks++;
    if (a_fd !== 1'b0 || a_ur !== 1'b0 || a_fp !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_status: got fd=%0d ur=%0d fp=%0d required 0 0 0", a_fd, a_ur, a_fp);
    end
    n_checks++;
    if (a_if.pixel_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %0d required 1", a_if.pixel_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (a_cmd !== 2'b00 || a_busy !== 1'b0 || b_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got cmd=%0d busy=%0d/%0d required 0 0/0", a_cmd, a_busy, b_busy);
    end
  endtask

  task automatic test_single_pixel(input string name);
    int ncyc;
    bit got_fd;
    npix   = 1;
    pix[0] = 24'hAA0000;
    drive_frame(1'b1, 1'b0, 24'h0, ncyc, got_fd);
    check_frame(name, 1'b1, 1'b0, ncyc, got_fd);
  endtask

  task automatic test_back_to_back();
    int ncyc;
    bit got_fd;
    npix   = 3;
    pix[0] = 24'hFFFFFF;
    pix[1] = 24'h000000;
    pix[2] = 24'h800001;
    drive_frame(1'b1, 1'b0, 24'h0, ncyc, got_fd);
    check_frame("back_to_back", 1'b1, 1'b0, ncyc, got_fd);
  endtask

  task automatic test_underrun();
    int ncyc;
    bit got_fd;
    npix = 2;
    for (int i = 0; i < npix; i++) pix[i] = 24'($urandom);
    drive_frame(1'b0, 1'b0, 24'h0, ncyc, got_fd);
    check_frame("underrun", 1'b0, 1'b0, ncyc, got_fd);
  endtask

  task automatic test_random_frames();
    int ncyc;
    bit got_fd;
    bit ml;
    for (int r = 0; r < 4; r++) begin
      npix = $urandom_range(1, 4);
      ml   = 1'($urandom_range(0, 1));
      for (int i = 0; i < npix; i++) pix[i] = 24'($urandom);
      drive_frame(ml, 1'b0, 24'h0, ncyc, got_fd);
      check_frame($sformatf("random%0d", r), ml, 1'b0, ncyc, got_fd);
    end
  endtask

  task automatic test_valid_during_latch();
    int          ncyc;
    bit          got_fd;
    logic [23:0] nxt;
    int          tx;
    int          c;
    bit          fd2;
    npix   = 1;
    pix[0] = 24'($urandom);
    nxt    = 24'($urandom);
    drive_frame(1'b1, 1'b1, nxt, ncyc, got_fd);
    check_frame("valid_in_latch", 1'b1, 1'b1, ncyc, got_fd);
    @(negedge clk);
    n_checks++;
    if (a_cmd !== 2'b01 || a_bit !== nxt[23]) begin
      n_fail++;
      $display("FAIL latch_resume: got cmd=%0d bit=%0d required 1 %0d", a_cmd, a_bit, nxt[23]);
    end
    tx  = (a_cmd === 2'b01) ? 1 : 0;
    fd2 = 1'b0;
    c   = 0;
    while (!fd2 && c < 300) begin
      @(negedge clk);
      if (a_cmd === 2'b01) tx++;
      fd2 = (a_fd === 1'b1);
      c++;
    end
    n_checks++;
    if (tx !== FB || !fd2) begin
      n_fail++;
      $display("FAIL latch_resume_frame: got %0d TX cycles done=%0d required %0d done=1", tx, fd2, FB);
    end
    n_checks++;
    if (a_fp !== 16'd1) begin
      n_fail++;
      $display("FAIL latch_resume_pixels: got %0d required 1", a_fp);
    end
  endtask

  task automatic test_async_reset();
    int idx = 0;
    int c   = 0;
    int t0  = -1;
    int bad = 0;
    bit hit = 1'b0;
    npix = 3;
    for (int i = 0; i < npix; i++) pix[i] = 24'($urandom);
    while (c < 600 && !hit) begin
      @(negedge clk);
      if (idx < npix) begin
        a_if.pixel_valid = 1'b1;
        a_if.pixel_data  = pix[idx];
        a_if.pixel_last  = (idx == npix - 1);
      end else begin
        a_if.pixel_valid = 1'b0;
      end
      if (a_if.pixel_valid && a_if.pixel_ready) idx++;
      if (t0 < 0 && a_cmd === 2'b01) t0 = c;
      if (t0 >= 0 && c == t0 + FB + 10 * BC + 1) hit = 1'b1;
      c++;
    end
    n_checks++;
    if (!hit || a_busy !== 1'b1 || a_cmd !== 2'b01) begin
      n_fail++;
      $display("FAIL pre_reset_active: got reached=%0d busy=%0d cmd=%0d required 1 1 1", hit, a_busy, a_cmd);
    end
    #2;
    rst = 1'b1;
    a_if.pixel_valid = 1'b0;
    #1;
    n_checks++;
    if (a_cmd !== 2'b00 || a_bit !== 1'b0 || a_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_line: got cmd=%0d bit=%0d busy=%0d required 0 0 0", a_cmd, a_bit, a_busy);
    end
    n_checks++;
    if (a_fd !== 1'b0 || a_ur !== 1'b0 || a_fp !== 16'd0) begin
      n_fail++;
      $display("FAIL async_reset_status: got fd=%0d ur=%0d fp=%0d required 0 0 0", a_fd, a_ur, a_fp);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2 * LC + 10; i++) begin
      @(negedge clk);
      if (a_fd !== 1'b0 || a_cmd !== 2'b00 || a_busy !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL discarded_frame: got %0d active or frame_done cycles after reset, required 0", bad);
    end
  endtask

  task automatic test_saturation();
    int          acc = 0;
    int          c   = 0;
    bit          fd  = 1'b0;
    logic [15:0] want_fp;
    while (acc < NSAT && c < NSAT + 2000) begin
      @(negedge clk);
      b_if.pixel_valid = 1'b1;
      b_if.pixel_data  = 1'($urandom);
      b_if.pixel_last  = (acc == NSAT - 1);
      if (b_if.pixel_valid && b_if.pixel_ready) acc++;
      c++;
    end
    @(posedge clk);
    #1;
    b_if.pixel_valid = 1'b0;
    n_checks++;
    if (acc !== NSAT) begin
      n_fail++;
      $display("FAIL sat_accepted: got %0d pixels accepted required %0d", acc, NSAT);
    end
    c = 0;
    while (!fd && c < 20) begin
      @(negedge clk);
      fd = (b_fd === 1'b1);
      c++;
    end
    want_fp = (acc > 65535) ? 16'hFFFF : 16'(acc);
    n_checks++;
    if (!fd || b_fp !== want_fp) begin
      n_fail++;
      $display("FAIL sat_frame_pixels: got %0h done=%0d required %0h done=1", b_fp, fd, want_fp);
    end
  endtask

  initial begin
    rst              = 1'b1;
    a_if.pixel_valid = 1'b0;
    a_if.pixel_data  = '0;
    a_if.pixel_last  = 1'b0;
    b_if.pixel_valid = 1'b0;
    b_if.pixel_data  = '0;
    b_if.pixel_last  = 1'b0;

    test_reset();
    test_single_pixel("single_pixel");
    test_back_to_back();
    test_underrun();
    test_valid_during_latch();
    test_random_frames();
    test_async_reset();
    test_single_pixel("post_reset_pixel");
    test_saturation();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
